sd_spi_responder: RTL and testbench
===================================

Name: sd_spi_responder

Overview:
- Synthesizable SPI-mode SD card responder: the card-side end of the SD interface driven by our `audio` block's SD initiator.
- Lets the audio/SD read path be simulated and FPGA-looped without a physical card.
- Decodes 48-bit command frames, returns R1/R7 responses, serves CMD17 single-block reads from a deterministic data pattern.
- Runs entirely on the system clock; the SPI clock is oversampled, never used as a clock.

Parameters:
- SYNC_STAGES, 2, flops in the SCK/MOSI/CS synchronizers.
- NCR_BYTES, 1, 0xFF bytes between command end and response byte.
- READ_LAT_BYTES, 4, 0xFF bytes between CMD17 R1 and the data token.
- INIT_RETRIES, 3, number of ACMD41 calls answered 0x01 before 0x00 (ready).
- BLOCK_BYTES, 512, data bytes per block.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous active-high reset.
- sd_reset_in  input  1  card power-off (high = unpowered).
- sd_sck_in  input  1  SPI clock from initiator.
- sd_cmd_in  input  1  MOSI command line.
- sd_cs_n_in  input  1  chip select (DAT3), active low.
- sd_dat0_out  output  1  MISO.
- ready_out  output  1  card has left idle (ACMD41 returned 0x00).
- cmd_count_out  output  16  valid commands decoded, saturating.

Behaviour:
- Reset (rst_in or sd_reset_in high): sd_dat0_out=1, ready_out=0, cmd_count_out=0, retry counter=INIT_RETRIES, app_cmd flag=0, FSM=IDLE.
- sd_reset_in is synchronous; rst_in is asynchronous.
- Edge detection:
  - sck, mosi and cs_n each pass through SYNC_STAGES flops; sck edges are detected against the previous synced value.
  - MOSI is sampled on the synced sck rising edge.
  - MISO updates on the synced sck falling edge (SPI mode 0).
  - Latency from pin to edge event is SYNC_STAGES+1 clk_in cycles; correct operation requires sck ≤ clk_in/8.
- FSM states: IDLE, RX_CMD, NCR, TX_RESP, RD_WAIT, TX_TOKEN, TX_DATA, TX_CRC.
  - IDLE: MISO=1. The first sampled 0 bit while cs_n low goes to RX_CMD; that bit counts as the frame's start bit.
  - RX_CMD: shift in 48 bits total.
    - Frame valid iff bit47=0, bit46=1, bit0=1. CRC is ignored.
    - Invalid frame → IDLE silently, no response, counter not incremented.
  - NCR: output NCR_BYTES×8 ones, then TX_RESP.
  - TX_RESP: shift the response MSB-first.
    - R1 is 8 bits; R7 is 40 bits.
    - Then go to RD_WAIT if a read was accepted, else IDLE.
  - RD_WAIT: READ_LAT_BYTES of 0xFF, then TX_TOKEN.
  - TX_TOKEN: send 0xFE, then TX_DATA.
  - TX_DATA: send BLOCK_BYTES bytes; byte k = (addr[7:0] + k[7:0]) mod 256, where addr = CMD17 argument. Then TX_CRC.
  - TX_CRC: send 0x0000, then IDLE.
- Command decoding (idx = bits 45:40, arg = bits 39:8). The app_cmd flag is set by CMD55 and cleared by any next command.
  - CMD0 → R1 0x01; clears ready_out; retry counter reloads to INIT_RETRIES.
  - CMD8 → R7 {0x01, 0x000001, arg[7:0]}.
  - CMD55 → R1 0x01 if not ready, 0x00 if ready.
  - ACMD41 (idx 41 with app_cmd set):
    - If retry counter > 0: R1 0x01 and decrement the counter.
    - Else: R1 0x00 and set ready_out.
  - CMD17 when ready → R1 0x00, then the block read. CMD17 when not ready → R1 0x05, no data.
  - CMD41 without app_cmd, or any other idx → R1 0x05 if not ready, 0x04 if ready.
  - cmd_count_out increments once per valid frame and saturates at 0xFFFF.
- Boundaries:
  - cs_n rising mid-operation (any state) → IDLE, MISO=1 next cycle; the partial frame is discarded and any pending response or read is aborted.
  - MOSI activity during NCR/TX states is ignored; no new command is recognized until IDLE.
  - Data byte index wraps mod 256 in the pattern; the byte counter itself counts to BLOCK_BYTES-1 exactly.
  - rst_in asserted mid-block → immediate reset values; no completion of the block.
  - sck edges while cs_n high are ignored.

Decomposition:
- Package sd_spi_pkg holds:
  - command index constants (CMD0, CMD8, CMD17, CMD41, CMD55);
  - R1 constants (R1_IDLE=0x01, R1_READY=0x00, R1_ILLEGAL=0x04);
  - DATA_TOKEN=0xFE;
  - the FSM state enum typedef.
- One sub-module, spi_edge_sync, holds the synchronizers plus sck rise/fall pulse generation and synced mosi/cs_n outputs.

Test Plan:
- Reset, then CMD0 (0x40 00000000 95) at sck=clk/8 → after 8 ones, MISO shifts 0x01; cmd_count_out=1; ready_out=0.
- CMD8 arg 0x000001AA → after NCR, R7 bits 0x01_000001_AA.
- CMD55+ACMD41 loop four times → R1 sequence 0x01,0x01,0x01,0x00; ready_out rises after the fourth ACMD41; subsequent CMD55 → 0x00.
- Once ready, CMD17 arg 0x00000010 → R1 0x00, four 0xFF, 0xFE, bytes 0x10,0x11,…,0x0F (512 bytes, wrapping at 0xFF→0x00), then 0x00,0x00, then MISO idle 1.
- CMD17 before ready → 0x05, no token within 16 following bytes; frame with bit0=0 → no response, cmd_count_out unchanged.
- Raise cs_n at data byte 100 → MISO=1 within SYNC_STAGES+2 cycles; a new CMD0 afterward answers 0x01 normally. Separately, pulse rst_in mid-read → MISO=1, ready_out=0 immediately.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// Shared constants and state type for the SPI-mode SD card responder.
package sd_spi_pkg;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;

    localparam logic [7:0] R1_IDLE    = 8'h01;
    localparam logic [7:0] R1_READY   = 8'h00;
    localparam logic [7:0] R1_ILLEGAL = 8'h04;
    localparam logic [7:0] DATA_TOKEN = 8'hFE;

    typedef enum logic [2:0] {
        IDLE,
        RX_CMD,
        NCR,
        TX_RESP,
        RD_WAIT,
        TX_TOKEN,
        TX_DATA,
        TX_CRC
    } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizes SCK/MOSI/CS_n into the system clock domain and emits
// registered single-cycle SCK rise/fall pulses aligned with synced MOSI/CS_n.
module spi_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic mosi,
    input  logic cs_n,
    output logic sck_rise,
    output logic sck_fall,
    output logic mosi_s,
    output logic cs_n_s
);

    logic [SYNC_STAGES-1:0] sck_sr;
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic [SYNC_STAGES-1:0] cs_sr;
    logic                   sck_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sr   <= '0;
            mosi_sr  <= '1;
            cs_sr    <= '1;
            sck_prev <= 1'b0;
            sck_rise <= 1'b0;
            sck_fall <= 1'b0;
            mosi_s   <= 1'b1;
            cs_n_s   <= 1'b1;
        end else begin
            sck_sr   <= SYNC_STAGES'({sck_sr, sck});
            mosi_sr  <= SYNC_STAGES'({mosi_sr, mosi});
            cs_sr    <= SYNC_STAGES'({cs_sr, cs_n});
            sck_prev <= sck_sr[SYNC_STAGES-1];
            sck_rise <= sck_sr[SYNC_STAGES-1] & ~sck_prev;
            sck_fall <= ~sck_sr[SYNC_STAGES-1] & sck_prev;
            // Extra stage keeps MOSI/CS_n aligned with the edge pulses
            mosi_s   <= mosi_sr[SYNC_STAGES-1];
            cs_n_s   <= cs_sr[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/sd_spi_responder.sv
// Card-side SPI-mode SD responder: decodes command frames, answers R1/R7,
// and serves CMD17 block reads from an address-seeded byte pattern.
module sd_spi_responder
    import sd_spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned NCR_BYTES      = 1,
    parameter int unsigned READ_LAT_BYTES = 4,
    parameter int unsigned INIT_RETRIES   = 3,
    parameter int unsigned BLOCK_BYTES    = 512
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        sd_reset_in,
    input  logic        sd_sck_in,
    input  logic        sd_cmd_in,
    input  logic        sd_cs_n_in,
    output logic        sd_dat0_out,
    output logic        ready_out,
    output logic [15:0] cmd_count_out
);

    localparam int unsigned    CNT_W        = 16;
    localparam logic [CNT_W-1:0] NCR_LAST   = CNT_W'(NCR_BYTES * 8 - 1);
    localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(READ_LAT_BYTES * 8 - 1);
    localparam logic [CNT_W-1:0] BLK_LAST   = CNT_W'(BLOCK_BYTES - 1);
    localparam logic [CNT_W-1:0] CRC_LAST   = CNT_W'(15);
    localparam logic [7:0]     RETRY_INIT   = 8'(INIT_RETRIES);
    localparam logic [5:0]     R1_LEN       = 6'd8;
    localparam logic [5:0]     R7_LEN       = 6'd40;

    logic sck_rise, sck_fall, mosi_s, cs_n_s;

    spi_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk_in),
        .rst     (rst_in),
        .sck     (sd_sck_in),
        .mosi    (sd_cmd_in),
        .cs_n    (sd_cs_n_in),
        .sck_rise(sck_rise),
        .sck_fall(sck_fall),
        .mosi_s  (mosi_s),
        .cs_n_s  (cs_n_s)
    );

    state_t             state_q, state_d;
    logic [46:0]        rx_q, rx_d;
    logic [5:0]         rx_cnt_q, rx_cnt_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [39:0]        resp_q, resp_d;
    logic [5:0]         resp_len_q, resp_len_d;
    logic [7:0]         addr_q, addr_d;
    logic               rd_pend_q, rd_pend_d;
    logic [7:0]         retry_q, retry_d;
    logic               app_cmd_q, app_cmd_d;
    logic               ready_q, ready_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               miso_q, miso_d;

    // Frame fields as they stand when the 48th bit (stop bit) is on mosi_s
    logic       rx_start, rx_tx, rx_stop;
    logic [5:0] rx_idx;
    logic [7:0] rx_arg_lo;
    assign rx_start  = rx_q[46];
    assign rx_tx     = rx_q[45];
    assign rx_idx    = rx_q[44:39];
    assign rx_arg_lo = rx_q[14:7];
    assign rx_stop   = mosi_s;

    assign sd_dat0_out   = miso_q;
    assign ready_out     = ready_q;
    assign cmd_count_out = cnt_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            rx_q       <= '0;
            rx_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            resp_q     <= '1;
            resp_len_q <= R1_LEN;
            addr_q     <= '0;
            rd_pend_q  <= 1'b0;
            retry_q    <= RETRY_INIT;
            app_cmd_q  <= 1'b0;
            ready_q    <= 1'b0;
            cnt_q      <= '0;
            miso_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            rx_q       <= rx_d;
            rx_cnt_q   <= rx_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            resp_q     <= resp_d;
            resp_len_q <= resp_len_d;
            addr_q     <= addr_d;
            rd_pend_q  <= rd_pend_d;
            retry_q    <= retry_d;
            app_cmd_q  <= app_cmd_d;
            ready_q    <= ready_d;
            cnt_q      <= cnt_d;
            miso_q     <= miso_d;
        end
    end

    always_comb begin
        logic [7:0] r1;
        logic [7:0] tx_byte;
        logic       is_r7;

        state_d    = state_q;
        rx_d       = rx_q;
        rx_cnt_d   = rx_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        resp_d     = resp_q;
        resp_len_d = resp_len_q;
        addr_d     = addr_q;
        rd_pend_d  = rd_pend_q;
        retry_d    = retry_q;
        app_cmd_d  = app_cmd_q;
        ready_d    = ready_q;
        cnt_d      = cnt_q;
        miso_d     = miso_q;
        r1         = ready_q ? R1_ILLEGAL : (R1_ILLEGAL | R1_IDLE);
        tx_byte    = DATA_TOKEN;
        is_r7      = 1'b0;

        if (cs_n_s) begin
            // Deselect aborts whatever is in flight
            state_d   = IDLE;
            miso_d    = 1'b1;
            rd_pend_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sck_fall) miso_d = 1'b1;
                    if (sck_rise && !mosi_s) begin
                        state_d  = RX_CMD;
                        rx_d     = {rx_q[45:0], mosi_s};
                        rx_cnt_d = 6'd1;
                    end
                end
                RX_CMD: begin
                    if (sck_rise) begin
                        rx_d     = {rx_q[45:0], mosi_s};
                        rx_cnt_d = rx_cnt_q + 6'd1;
                        if (rx_cnt_q == 6'd47) begin
                            if (!rx_start && rx_tx && rx_stop) begin
                                state_d   = NCR;
                                bit_cnt_d = '0;
                                cnt_d     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                                app_cmd_d = 1'b0;
                                rd_pend_d = 1'b0;
                                case (rx_idx)
                                    CMD0: begin
                                        r1      = R1_IDLE;
                                        ready_d = 1'b0;
                                        retry_d = RETRY_INIT;
                                    end
                                    CMD8: is_r7 = 1'b1;
                                    CMD55: begin
                                        r1        = ready_q ? R1_READY : R1_IDLE;
                                        app_cmd_d = 1'b1;
                                    end
                                    CMD41: begin
                                        if (app_cmd_q) begin
                                            if (retry_q != 8'd0) begin
                                                r1      = R1_IDLE;
                                                retry_d = retry_q - 8'd1;
                                            end else begin
                                                r1      = R1_READY;
                                                ready_d = 1'b1;
                                            end
                                        end
                                    end
                                    CMD17: begin
                                        if (ready_q) begin
                                            r1        = R1_READY;
                                            rd_pend_d = 1'b1;
                                            addr_d    = rx_arg_lo;
                                        end
                                    end
                                    default: ;
                                endcase
                                resp_d     = is_r7 ? {R1_IDLE, 24'h000001, rx_arg_lo} : {r1, 32'h0};
                                resp_len_d = is_r7 ? R7_LEN : R1_LEN;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
                NCR: begin
                    if (sck_fall) begin
                        miso_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == NCR_LAST) begin
                            state_d   = TX_RESP;
                            bit_cnt_d = '0;
                        end
                    end
                end
                TX_RESP: begin
                    if (sck_fall) begin
                        miso_d    = resp_q[39];
                        resp_d    = {resp_q[38:0], 1'b1};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == CNT_W'(resp_len_q - 6'd1)) begin
                            state_d   = rd_pend_q ? RD_WAIT : IDLE;
                            bit_cnt_d = '0;
                        end
                    end
                end
                RD_WAIT: begin
                    if (sck_fall) begin
                        miso_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAT_LAST) begin
                            state_d   = TX_TOKEN;
                            bit_cnt_d = '0;
                        end
                    end
                end
                TX_TOKEN: begin
                    if (sck_fall) begin
                        miso_d    = tx_byte[~bit_cnt_q[2:0]];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q[2:0] == 3'd7) begin
                            state_d    = TX_DATA;
                            bit_cnt_d  = '0;
                            byte_cnt_d = '0;
                        end
                    end
                end
                TX_DATA: begin
                    tx_byte = addr_q + byte_cnt_q[7:0];
                    if (sck_fall) begin
                        miso_d    = tx_byte[~bit_cnt_q[2:0]];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q[2:0] == 3'd7) begin
                            bit_cnt_d = '0;
                            if (byte_cnt_q == BLK_LAST) begin
                                state_d = TX_CRC;
                            end else begin
                                byte_cnt_d = byte_cnt_q + 1'b1;
                            end
                        end
                    end
                end
                TX_CRC: begin
                    if (sck_fall) begin
                        miso_d    = 1'b0;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == CRC_LAST) begin
                            state_d   = IDLE;
                            bit_cnt_d = '0;
                            rd_pend_d = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Card power-off behaves as a synchronous reset of card state
        if (sd_reset_in) begin
            state_d   = IDLE;
            rd_pend_d = 1'b0;
            retry_d   = RETRY_INIT;
            app_cmd_d = 1'b0;
            ready_d   = 1'b0;
            cnt_d     = '0;
            miso_d    = 1'b1;
        end
    end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: an SPI mode-0 initiator at sck=clk/8
// walks the init sequence, block reads, invalid frames, deselect and reset.
module tb_sd_spi_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sd_reset;
    logic        sck;
    logic        mosi;
    logic        cs_n;
    logic        dat0;
    logic        ready;
    logic [15:0] count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sd_spi_responder dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .sd_reset_in  (sd_reset),
        .sd_sck_in    (sck),
        .sd_cmd_in    (mosi),
        .sd_cs_n_in   (cs_n),
        .sd_dat0_out  (dat0),
        .ready_out    (ready),
        .cmd_count_out(count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One mode-0 byte: MOSI set while SCK low, MISO sampled at the rising edge
    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            repeat (4) @(negedge clk);
            rx[i] = dat0;
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
        logic [7:0] d;
        xfer({2'b01, idx}, d);
        for (int i = 3; i >= 0; i--) xfer(arg[8*i +: 8], d);
        xfer(crc, d);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic [7:0] d;
        xfer(8'hFF, d);
        check(tag, 32'(d), 32'(exp));
    endtask

    task automatic cmd_r1(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                          input logic [7:0] crc, input logic [7:0] exp_r1);
        send_cmd(idx, arg, crc);
        expect_byte({tag, "_ncr"}, 8'hFF);
        expect_byte(tag, exp_r1);
    endtask

    task automatic init_loop();
        for (int i = 0; i < 4; i++) begin
            cmd_r1("cmd55", 6'd55, 32'h0, 8'h01, 8'h01);
            cmd_r1("acmd41", 6'd41, 32'h4000_0000, 8'h77, (i < 3) ? 8'h01 : 8'h00);
            check("ready_loop", 32'(ready), (i == 3) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic read_head(input logic [31:0] arg);
        cmd_r1("cmd17", 6'd17, arg, 8'h01, 8'h00);
        for (int i = 0; i < 4; i++) expect_byte("rd_lat", 8'hFF);
        expect_byte("token", 8'hFE);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e;
        rst      = 1'b1;
        sd_reset = 1'b0;
        sck      = 1'b0;
        mosi     = 1'b1;
        cs_n     = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_miso", 32'(dat0), 32'd1);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);

        cmd_r1("cmd0", 6'd0, 32'h0, 8'h95, 8'h01);
        check("cmd0_count", 32'(count), 32'd1);
        check("cmd0_ready", 32'(ready), 32'd0);

        send_cmd(6'd8, 32'h0000_01AA, 8'h87);
        expect_byte("cmd8_ncr", 8'hFF);
        expect_byte("r7_b0", 8'h01);
        expect_byte("r7_b1", 8'h00);
        expect_byte("r7_b2", 8'h00);
        expect_byte("r7_b3", 8'h01);
        expect_byte("r7_b4", 8'hAA);

        cmd_r1("cmd17_notready", 6'd17, 32'h0, 8'h01, 8'h05);
        for (int i = 0; i < 16; i++) expect_byte("no_token", 8'hFF);
        check("count_3", 32'(count), 32'd3);

        // Stop bit cleared: frame must be dropped silently
        send_cmd(6'd0, 32'h0, 8'h94);
        expect_byte("inv_quiet0", 8'hFF);
        expect_byte("inv_quiet1", 8'hFF);
        check("inv_count", 32'(count), 32'd3);

        init_loop();
        cmd_r1("cmd55_ready", 6'd55, 32'h0, 8'h01, 8'h00);
        cmd_r1("cmd13_ready", 6'd13, 32'h0, 8'h01, 8'h04);
        check("count_13", 32'(count), 32'd13);

        read_head(32'h0000_0010);
        for (int k = 0; k < 512; k++) begin
            e = 8'(k + 16);
            expect_byte("data", e);
        end
        expect_byte("crc0", 8'h00);
        expect_byte("crc1", 8'h00);
        expect_byte("post_idle", 8'hFF);

        // Deselect part way through a block
        read_head(32'h0000_00F0);
        for (int k = 0; k < 100; k++) begin
            e = 8'(k + 240);
            expect_byte("data_ab", e);
        end
        repeat (6) @(negedge clk);
        check("abort_pre", 32'(dat0), 32'd0);
        cs_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_miso", 32'(dat0), 32'd1);
        repeat (8) @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        cmd_r1("cmd0_after", 6'd0, 32'h0, 8'h95, 8'h01);
        check("after_ready", 32'(ready), 32'd0);
        check("count_16", 32'(count), 32'd16);

        // Asynchronous reset mid-block
        init_loop();
        read_head(32'h0000_0000);
        for (int k = 0; k < 10; k++) begin
            e = 8'(k);
            expect_byte("data_rst", e);
        end
        repeat (6) @(negedge clk);
        check("rst_pre_miso", 32'(dat0), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_mid_miso", 32'(dat0), 32'd1);
        check("rst_mid_ready", 32'(ready), 32'd0);
        check("rst_mid_count", 32'(count), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Card power-off clears the command counter
        cmd_r1("cmd0_post_rst", 6'd0, 32'h0, 8'h95, 8'h01);
        check("count_post_rst", 32'(count), 32'd1);
        sd_reset = 1'b1;
        repeat (2) @(negedge clk);
        check("sd_reset_count", 32'(count), 32'd0);
        sd_reset = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
